// File: rtl/ifetch_task_scheduler_pkg.sv
// Shared constants, FSM encoding and task-index helpers for the ifetch task scheduler.
// A task index is chan*NTHREAD + thread; power-of-2 sizes make the divide/modulo plain bit slices.
package ifetch_task_scheduler_pkg;

  localparam int NCHAN    = 8;
  localparam int CHAN_W   = 3;
  localparam int NTHREAD  = 2;
  localparam int THREAD_W = 1;
  localparam int PC_W     = 12;
  localparam int NTASK    = NCHAN * NTHREAD;
  localparam int IDX_W    = $clog2(NTASK);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_JUMP  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  function automatic logic [CHAN_W-1:0] idx_chan(input logic [IDX_W-1:0] idx);
    return CHAN_W'(idx / IDX_W'(NTHREAD));
  endfunction

  function automatic logic [THREAD_W-1:0] idx_thread(input logic [IDX_W-1:0] idx);
    return THREAD_W'(idx % IDX_W'(NTHREAD));
  endfunction

endpackage

// File: rtl/ifetch_task_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr+1 (mod N) wins.
// Zero latency; no backpressure, gnt_vld simply drops when nothing requests.
module ifetch_task_scheduler_rr_arbiter #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  logic [W-1:0] cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(ptr) + i) % N);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt = gnt_vld ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/ifetch_task_scheduler.sv
// Round-robin task scheduler for ifetch: grant -> ready strobe (+1) -> jump strobe (+2) -> run until suspend.
// Dispatch waits for fetch_idle; wakes are absorbed every cycle; suspend outside RUN is ignored.
module ifetch_task_scheduler
  import ifetch_task_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NTASK-1:0]    wake,
  input  logic                fetch_idle,
  input  logic                suspend_valid,
  input  logic [PC_W-1:0]     suspend_pc,
  output logic [CHAN_W-1:0]   next_task_channel,
  output logic [THREAD_W-1:0] next_task_thread,
  output logic                next_task_ready,
  output logic [PC_W-1:0]     jump_target,
  output logic                jump_enable,
  output logic                task_active,
  output logic [NTASK-1:0]    runnable
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
  logic [NTASK-1:0]      gnt_oh_q, gnt_oh_d;
  logic [CHAN_W-1:0]     chan_q, chan_d;
  logic [THREAD_W-1:0]   thread_q, thread_d;
  logic [NTASK-1:0]      runnable_q, runnable_d;
  logic                  task_active_q, task_active_d;
  logic [PC_W-1:0]       pc_q [NTASK];
  logic [PC_W-1:0]       pc_d [NTASK];

  logic [NTASK-1:0]      arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_vld;

  ifetch_task_scheduler_rr_arbiter #(.N(NTASK), .W(IDX_W)) u_arb (
    .req     (runnable_q),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    gnt_idx_d       = gnt_idx_q;
    gnt_oh_d        = gnt_oh_q;
    chan_d          = chan_q;
    thread_d        = thread_q;
    runnable_d      = runnable_q;
    task_active_d   = task_active_q;
    pc_d            = pc_q;
    next_task_ready = 1'b0;
    jump_enable     = 1'b0;
    jump_target     = '0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_idle && arb_vld) begin
          ptr_d     = arb_idx;
          gnt_idx_d = arb_idx;
          gnt_oh_d  = arb_gnt;
          chan_d    = idx_chan(arb_idx);
          thread_d  = idx_thread(arb_idx);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        next_task_ready = 1'b1;
        state_d         = ST_JUMP;
      end
      ST_JUMP: begin
        jump_enable   = 1'b1;
        jump_target   = pc_q[gnt_idx_q];
        task_active_d = 1'b1;
        state_d       = ST_RUN;
      end
      ST_RUN: begin
        if (suspend_valid) begin
          pc_d[gnt_idx_q] = suspend_pc;
          runnable_d      = runnable_q & ~gnt_oh_q;
          task_active_d   = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Wake is applied after the suspend clear so a same-cycle wake keeps the task runnable.
    runnable_d = runnable_d | wake;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= IDX_W'(NTASK - 1);
      gnt_idx_q     <= '0;
      gnt_oh_q      <= '0;
      chan_q        <= '0;
      thread_q      <= '0;
      runnable_q    <= '0;
      task_active_q <= 1'b0;
      for (int i = 0; i < NTASK; i++) pc_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_idx_q     <= gnt_idx_d;
      gnt_oh_q      <= gnt_oh_d;
      chan_q        <= chan_d;
      thread_q      <= thread_d;
      runnable_q    <= runnable_d;
      task_active_q <= task_active_d;
      pc_q          <= pc_d;
    end
  end

  assign next_task_channel = chan_q;
  assign next_task_thread  = thread_q;
  assign task_active       = task_active_q;
  assign runnable          = runnable_q;

endmodule

// File: tb/tb_ifetch_task_scheduler.sv
// Scoreboard bench for ifetch_task_scheduler: stimulus pushes expected grants, a negedge monitor pops and checks them.
module tb_ifetch_task_scheduler;
  import ifetch_task_scheduler_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [NTASK-1:0]    wake;
  logic                fetch_idle;
  logic                suspend_valid;
  logic [PC_W-1:0]     suspend_pc;
  logic [CHAN_W-1:0]   next_task_channel;
  logic [THREAD_W-1:0] next_task_thread;
  logic                next_task_ready;
  logic [PC_W-1:0]     jump_target;
  logic                jump_enable;
  logic                task_active;
  logic [NTASK-1:0]    runnable;

  always #5 clk = ~clk;

  ifetch_task_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .wake              (wake),
    .fetch_idle        (fetch_idle),
    .suspend_valid     (suspend_valid),
    .suspend_pc        (suspend_pc),
    .next_task_channel (next_task_channel),
    .next_task_thread  (next_task_thread),
    .next_task_ready   (next_task_ready),
    .jump_target       (jump_target),
    .jump_enable       (jump_enable),
    .task_active       (task_active),
    .runnable          (runnable)
  );

  typedef struct {
    int chan;
    int thread;
    int pc;
  } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  int   ready_cyc[$];
  int   cyc = 0;

  // Reference model: set of runnable tasks, last granted index, saved PC per task.
  bit [15:0] m_run;
  int        m_ptr;
  int        m_cur;
  int        m_pc[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int model_pick();
    for (int i = 1; i <= 16; i++) begin
      int k;
      k = (m_ptr + i) % 16;
      if (m_run[k]) return k;
    end
    return -1;
  endfunction

  // Monitor: every ready must match the head of the queue and be followed by exactly one jump.
  bit   pend = 1'b0;
  int   pend_pc = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("jump_enable_after_ready", int'(jump_enable), 1);
        chk("jump_target", int'(jump_target), pend_pc);
        pend = 1'b0;
      end else if (jump_enable) begin
        chk("spurious_jump_enable", int'(jump_enable), 0);
      end
      if (next_task_ready) begin
        ready_cyc.push_back(cyc);
        chk("ready_jump_overlap", int'(jump_enable), 0);
        if (exp_q.size() == 0) begin
          chk("spurious_ready", int'(next_task_ready), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant_channel", int'(next_task_channel), mon_e.chan);
          chk("grant_thread", int'(next_task_thread), mon_e.thread);
          pend    = 1'b1;
          pend_pc = mon_e.pc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, int'(next_task_ready), 0);
    chk({tag, "_jump_en"}, int'(jump_enable), 0);
    chk({tag, "_jump_target"}, int'(jump_target), 0);
    chk({tag, "_active"}, int'(task_active), 0);
    chk({tag, "_runnable"}, int'(runnable), 0);
    chk({tag, "_chan"}, int'(next_task_channel), 0);
    chk({tag, "_thread"}, int'(next_task_thread), 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    wake = '0;
    fetch_idle = 1'b0;
    suspend_valid = 1'b0;
    suspend_pc = '0;
    #1;
    check_all_zero(tag);
    m_run = '0;
    m_ptr = 15;
    m_cur = 0;
    for (int i = 0; i < 16; i++) m_pc[i] = 0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic pulse_wake(input bit [15:0] m);
    wake = m;
    m_run |= m;
    tick();
    wake = '0;
  endtask

  task automatic wait_active(input bit want);
    int n = 0;
    while (task_active !== want && n < 20) begin
      tick();
      n++;
    end
    chk("task_active_wait", int'(task_active), int'(want));
  endtask

  task automatic push_grant();
    exp_t e;
    int   g;
    g = model_pick();
    e.chan = g / NTHREAD;
    e.thread = g % NTHREAD;
    e.pc = m_pc[g];
    exp_q.push_back(e);
    m_ptr = g;
    m_cur = g;
  endtask

  task automatic dispatch(output bit ok);
    ok = (m_run != 0);
    if (ok) begin
      push_grant();
      fetch_idle = 1'b1;
      wait_active(1'b1);
      fetch_idle = 1'b0;
      chk("runnable_while_running", int'(runnable), int'(m_run));
    end
  endtask

  task automatic suspend(input int pc, input bit [15:0] also_wake);
    suspend_valid = 1'b1;
    suspend_pc = PC_W'(pc);
    wake = also_wake;
    tick();
    suspend_valid = 1'b0;
    wake = '0;
    m_pc[m_cur] = pc;
    m_run[m_cur] = 1'b0;
    m_run |= also_wake;
    chk("active_after_suspend", int'(task_active), 0);
    chk("runnable_after_suspend", int'(runnable), int'(m_run));
  endtask

  task automatic idle_suspend(input int pc);
    suspend_valid = 1'b1;
    suspend_pc = PC_W'(pc);
    tick();
    suspend_valid = 1'b0;
    chk("runnable_after_idle_suspend", int'(runnable), int'(m_run));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n0;
    int base;
    do_reset("reset_init");

    // Reset mid-RUN, then wake task 6 -> chan 3 thread 0 target 0.
    pulse_wake(16'h0004);
    dispatch(ok);
    do_reset("reset_mid_run");
    pulse_wake(16'h0040);
    dispatch(ok);

    // Save PC 0A5 on task 6 and regrant it.
    suspend(12'h0A5, 16'h0000);
    chk("task6_cleared", int'(runnable[6]), 0);
    pulse_wake(16'h0040);
    dispatch(ok);
    suspend(12'h011, 16'h0000);

    // Round-robin order 0, 8, 15 then wrap to 0.
    do_reset("reset_rr");
    pulse_wake(16'h8101);
    for (int i = 0; i < 3; i++) begin
      dispatch(ok);
      suspend(100 + i, 16'h0000);
    end
    pulse_wake(16'h0001);
    dispatch(ok);
    // Same-cycle wake and suspend of the running task keeps it runnable.
    suspend(12'h3C3, 16'h0001);
    chk("wake_wins_bit0", int'(runnable[0]), 1);
    dispatch(ok);
    suspend(12'h001, 16'h0000);

    // fetch_idle low: no dispatch; suspend in IDLE is ignored.
    pulse_wake(16'h0C30);
    n0 = ready_cyc.size();
    idle_suspend(12'hFFF);
    repeat (6) tick();
    chk("no_grant_without_fetch_idle", ready_cyc.size(), n0);
    chk("active_stays_low", int'(task_active), 0);
    for (int i = 0; i < 3; i++) begin
      dispatch(ok);
      suspend(200 + i, 16'h0000);
    end

    // Single task re-suspending with fetch_idle held high -> regrant every 4 cycles.
    do_reset("reset_single");
    pulse_wake(16'h0020);
    base = ready_cyc.size();
    fetch_idle = 1'b1;
    for (int r = 0; r < 5; r++) begin
      push_grant();
      wait_active(1'b1);
      if (r == 4) fetch_idle = 1'b0;
      suspend(int'($urandom_range(0, 4095)), 16'h0020);
    end
    repeat (4) tick();
    chk("single_task_grant_count", ready_cyc.size() - base, 5);
    for (int r = 1; r < 5; r++) begin
      if (base + r < ready_cyc.size())
        chk("regrant_period", ready_cyc[base + r] - ready_cyc[base + r - 1], 4);
    end

    // Randomized mix of wakes, idle suspends, dispatches and suspends.
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) pulse_wake(16'($urandom & $urandom & 32'hFFFF));
      if ($urandom_range(0, 3) == 0) idle_suspend(int'($urandom_range(0, 4095)));
      dispatch(ok);
      if (ok) begin
        repeat ($urandom_range(0, 3)) tick();
        if ($urandom_range(0, 3) == 0)
          suspend(int'($urandom_range(0, 4095)), 16'(1 << m_cur) | 16'($urandom & $urandom));
        else
          suspend(int'($urandom_range(0, 4095)), 16'($urandom & $urandom & $urandom));
      end
    end

    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
